// File: rtl/tape_fsk_sequencer_pkg.sv
// Shared types and framing constants for the cassette FSK sequencer.
package tape_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_DONE = 2'd2
    } tape_state_e;

    localparam int   FRAME_BITS  = 10;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/tape_fsk_sequencer_if.sv
// Byte handshake and status bundle between the I/O-port decode and the sequencer.
interface tape_fsk_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       busy;
    logic       phase_err;

    modport master (output in_data, in_valid, abort, input in_ready, busy, phase_err);
    modport slave  (input in_data, in_valid, abort, output in_ready, busy, phase_err);
endinterface

// File: rtl/tape_fsk_sequencer_tone_timer.sv
// Half-tone down-counter with terminal-count pulse, plus a toggle counter that
// flags the last toggle of the current bit.
module tape_tone_timer #(
    parameter int CNT_W = 8,
    parameter int TOG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] reload_val,
    input  logic [TOG_W-1:0] tog_target,
    output logic             tc,
    output logic             bit_end
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TOG_W-1:0] tog_q, tog_d;

    assign tc      = run && (cnt_q == '0);
    assign bit_end = tc && ((tog_q + TOG_W'(1)) == tog_target);

    always_comb begin
        cnt_d = cnt_q;
        tog_d = tog_q;
        if (load) begin
            cnt_d = load_val;
            tog_d = '0;
        end else if (tc) begin
            cnt_d = reload_val;
            tog_d = tog_q + TOG_W'(1);
        end else if (run) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tog_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end
endmodule

// File: rtl/tape_fsk_sequencer.sv
// Frames a byte as {stop, data, start} and toggles an external JK flip-flop at
// the FSK half-tone rate of each bit.
//   state   | meaning
//   ST_IDLE | flip-flop held cleared, waiting for a byte
//   ST_BIT  | toggling the flip-flop for the current bit
//   ST_DONE | one clock to check the flip-flop came back to 0
module tape_fsk_sequencer
    import tape_pkg::*;
#(
    parameter int HALF_0   = 8,
    parameter int CYCLES_0 = 2,
    parameter int HALF_1   = 4,
    parameter int CYCLES_1 = 4,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    tape_fsk_sequencer_if.slave  host,
    output logic                 ff_j,
    output logic                 ff_k,
    output logic                 ff_clk,
    output logic                 ff_clrn,
    input  logic                 ff_q
);
    localparam logic [CNT_W-1:0] HM1_0 = CNT_W'(HALF_0 - 1);
    localparam logic [CNT_W-1:0] HM1_1 = CNT_W'(HALF_1 - 1);
    localparam int MAX_CYC = (CYCLES_0 > CYCLES_1) ? CYCLES_0 : CYCLES_1;
    localparam int TOG_W   = $clog2(2 * MAX_CYC + 1);
    localparam logic [TOG_W-1:0] TOG_0 = TOG_W'(2 * CYCLES_0);
    localparam logic [TOG_W-1:0] TOG_1 = TOG_W'(2 * CYCLES_1);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

    tape_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            idx_q, idx_d;
    logic                  phase_err_q, phase_err_d;
    logic                  ff_clk_q, ff_clk_d;
    logic                  active_q, active_d;
    logic                  in_ready_q, in_ready_d;

    logic             tmr_load, tmr_run, tc, bit_end;
    logic [CNT_W-1:0] load_val, reload_val;
    logic [TOG_W-1:0] tog_target;

    function automatic logic [CNT_W-1:0] half_m1(input logic b);
        return b ? HM1_1 : HM1_0;
    endfunction

    // frame_q shifts right as bits complete, so bit 0 is always the current bit.
    assign reload_val = half_m1(frame_q[0]);
    assign tog_target = frame_q[0] ? TOG_1 : TOG_0;

    tape_tone_timer #(.CNT_W(CNT_W), .TOG_W(TOG_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .run        (tmr_run),
        .load_val   (load_val),
        .reload_val (reload_val),
        .tog_target (tog_target),
        .tc         (tc),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        phase_err_d = phase_err_q;
        ff_clk_d    = 1'b0;
        tmr_load    = 1'b0;
        tmr_run     = 1'b0;
        load_val    = half_m1(frame_q[0]);
        case (state_q)
            ST_IDLE: begin
                if (host.in_valid) begin
                    frame_d     = {STOP_LEVEL, host.in_data, START_LEVEL};
                    idx_d       = '0;
                    phase_err_d = 1'b0;
                    tmr_load    = 1'b1;
                    load_val    = half_m1(START_LEVEL);
                    state_d     = ST_BIT;
                end
            end
            ST_BIT: begin
                if (host.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_run = 1'b1;
                    if (tc) begin
                        ff_clk_d = 1'b1;
                        if (bit_end) begin
                            if (idx_q == LAST_IDX) begin
                                state_d = ST_DONE;
                            end else begin
                                idx_d    = idx_q + 4'd1;
                                frame_d  = {1'b0, frame_q[FRAME_BITS-1:1]};
                                tmr_load = 1'b1;
                                load_val = half_m1(frame_q[1]);
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!host.abort && ff_q) phase_err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        active_d   = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
    end

    // Pin controls come straight from flops so the async clear-bar never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            idx_q       <= '0;
            phase_err_q <= 1'b0;
            ff_clk_q    <= 1'b0;
            active_q    <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            phase_err_q <= phase_err_d;
            ff_clk_q    <= ff_clk_d;
            active_q    <= active_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign ff_j           = active_q;
    assign ff_k           = active_q;
    assign ff_clrn        = active_q;
    assign ff_clk         = ff_clk_q;
    assign host.busy      = active_q;
    assign host.in_ready  = in_ready_q;
    assign host.phase_err = phase_err_q;
endmodule

// File: tb/tb_tape_fsk_sequencer.sv
// Bench for tape_fsk_sequencer: JK toggle flip-flop model, frame-timing model
// checked every cycle, and ff_q period decoding back into bytes.
module tb_tape_fsk_sequencer;
    localparam int H0 = 8;
    localparam int C0 = 2;
    localparam int H1 = 4;
    localparam int C1 = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ff_j, ff_k, ff_clk, ff_clrn;
    logic ff_q = 1'b0;

    tape_fsk_sequencer_if hif();

    tape_fsk_sequencer #(
        .HALF_0(H0), .CYCLES_0(C0), .HALF_1(H1), .CYCLES_1(C1), .CNT_W(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .host    (hif),
        .ff_j    (ff_j),
        .ff_k    (ff_k),
        .ff_clk  (ff_clk),
        .ff_clrn (ff_clrn),
        .ff_q    (ff_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // External JK flip-flop wired as a toggle; one toggle can be swallowed.
    int ff_tog = 0;
    int supp_at = -1;
    always @(posedge ff_clk or negedge ff_clrn) begin
        if (!ff_clrn) ff_q <= 1'b0;
        else if (ff_j && ff_k) begin
            ff_tog++;
            if (ff_tog != supp_at) ff_q <= ~ff_q;
        end
    end

    // Frame model: offsets (from the acceptance edge) at which ff_clk is high.
    bit m_active = 0;
    bit m_perr = 0;
    int m_t0 = 0;
    bit m_map[0:320];
    int m_np = 0, m_first = 0, m_last = 0;

    task automatic build_map(input logic [7:0] d);
        int off;
        bit b;
        for (int i = 0; i <= 320; i++) m_map[i] = 0;
        off = 0;
        m_np = 0;
        for (int i = 0; i < 10; i++) begin
            b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            for (int k = 0; k < 2 * (b ? C1 : C0); k++) begin
                off += b ? H1 : H0;
                if (off <= 320) m_map[off] = 1;
                m_np++;
                if (m_np == 1) m_first = off;
            end
        end
        m_last = off;
    endtask

    int dpulses = 0;
    int hi_len = 0;
    int hi_q[$];

    always @(negedge clk) begin
        int d;
        bit e_clk;
        if (reset) begin
            m_active = 0;
            m_perr = 0;
            hi_len = 0;
        end else begin
            d = cyc - m_t0;
            e_clk = m_active && d >= 0 && d <= 320 && m_map[d];
            chk("busy", hif.busy, m_active);
            chk("in_ready", hif.in_ready, !m_active);
            chk("ff_clrn", ff_clrn, m_active);
            chk("ff_j", ff_j, m_active);
            chk("ff_k", ff_k, m_active);
            chk("ff_clk", ff_clk, e_clk);
            chk("phase_err", hif.phase_err, m_perr);
            if (ff_clk) dpulses++;
            if (ff_q) hi_len++;
            else if (hi_len > 0) begin
                hi_q.push_back(hi_len);
                hi_len = 0;
            end
            if (m_active) begin
                if (hif.abort) m_active = 0;
                else if (cyc + 1 - m_t0 == 321) begin
                    m_active = 0;
                    if (ff_q) m_perr = 1;
                end
            end else if (hif.in_valid) begin
                m_active = 1;
                m_t0 = cyc + 1;
                m_perr = 0;
                build_map(hif.in_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit hold, output int t0);
        bit rdy;
        hif.in_data = b;
        hif.in_valid = 1'b1;
        t0 = -1;
        for (int i = 0; i < 2000; i++) begin
            rdy = hif.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                t0 = cyc;
                break;
            end
        end
        chk("accept_seen", (t0 >= 0), 1);
        if (!hold) hif.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int t0);
        int te;
        te = -1;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (!hif.busy) begin
                te = cyc;
                break;
            end
        end
        chk("frame_end_offset", te - t0, 321);
    endtask

    // Each high run of ff_q lasts one half tone: H0 for a 0 bit, H1 for a 1 bit.
    task automatic decode_check(input int start, input logic [7:0] b0, input logic [7:0] b1, input int n);
        bit bits[$];
        bit bad;
        int i;
        logic [7:0] g;
        bad = 0;
        i = start;
        while (i < hi_q.size()) begin
            if (hi_q[i] == H0) begin
                bits.push_back(1'b0);
                i += C0;
            end else if (hi_q[i] == H1) begin
                bits.push_back(1'b1);
                i += C1;
            end else begin
                bad = 1;
                i++;
            end
        end
        chk("decode_bits", bits.size(), 10 * n);
        chk("decode_runs_valid", bad, 0);
        for (int f = 0; f < n; f++) begin
            if (bits.size() >= 10 * (f + 1)) begin
                for (int j = 0; j < 8; j++) g[j] = bits[f*10 + 1 + j];
                chk("decode_start", bits[f*10], 0);
                chk("decode_stop", bits[f*10 + 9], 1);
                chk("decode_byte", g, (f == 0) ? b0 : b1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1);
    end

    initial begin
        int t0, t1, s, dp;
        hif.in_data = 8'h00;
        hif.in_valid = 1'b0;
        hif.abort = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", hif.in_ready, 1);
        chk("rst_busy", hif.busy, 0);
        chk("rst_ff_clrn", ff_clrn, 0);
        chk("rst_ff_clk", ff_clk, 0);
        chk("rst_phase_err", hif.phase_err, 0);
        reset = 1'b0;

        tick(1000);
        chk("idle_pulses", dpulses, 0);
        chk("idle_clrn", ff_clrn, 0);

        // 0x00: nine 0 bits of 4 toggles at H0, stop bit of 8 toggles at H1
        s = hi_q.size();
        dp = dpulses;
        send(8'h00, 0, t0);
        wait_idle(t0);
        chk("pulses_00", dpulses - dp, 44);
        chk("model_np_00", m_np, 44);
        chk("model_first_00", m_first, 8);
        chk("model_last_00", m_last, 320);
        chk("perr_00", hif.phase_err, 0);
        decode_check(s, 8'h00, 8'h00, 1);

        s = hi_q.size();
        dp = dpulses;
        send(8'hFF, 0, t0);
        wait_idle(t0);
        chk("pulses_ff", dpulses - dp, 76);
        chk("model_np_ff", m_np, 76);
        chk("model_first_ff", m_first, 8);
        decode_check(s, 8'hFF, 8'h00, 1);

        // Back-to-back: in_ready rises after edge T0+321, handshake sampled at T0+322
        s = hi_q.size();
        dp = dpulses;
        send(8'hA5, 1, t0);
        send(8'h3C, 0, t1);
        chk("b2b_gap", t1 - t0, 322);
        wait_idle(t1);
        chk("pulses_b2b", dpulses - dp, 120);
        decode_check(s, 8'hA5, 8'h3C, 2);

        // abort while idle is ignored, then abort mid-frame
        hif.abort = 1'b1;
        send(8'h5A, 0, t0);
        hif.abort = 1'b0;
        chk("abort_idle_ignored", hif.busy, 1);
        for (int i = 0; i < 200 && cyc < t0 + 100; i++) tick(1);
        hif.abort = 1'b1;
        dp = dpulses;
        tick(1);
        hif.abort = 1'b0;
        chk("abort_clrn", ff_clrn, 0);
        chk("abort_ready", hif.in_ready, 1);
        chk("abort_ff_clk", ff_clk, 0);
        tick(40);
        chk("abort_no_pulses", dpulses - dp, 0);
        chk("abort_perr", hif.phase_err, 0);
        chk("abort_ff_q", ff_q, 0);

        // swallow one toggle: flip-flop ends high, phase_err sticks until next accept
        send(8'h00, 0, t0);
        tick(20);
        supp_at = ff_tog + 1;
        wait_idle(t0);
        chk("perr_set", hif.phase_err, 1);
        tick(5);
        chk("perr_sticky", hif.phase_err, 1);
        send(8'h01, 0, t1);
        chk("perr_cleared", hif.phase_err, 0);
        wait_idle(t1);
        chk("perr_clean_frame", hif.phase_err, 0);

        // async reset mid-frame
        send(8'h33, 0, t0);
        for (int i = 0; i < 200 && cyc < t0 + 49; i++) tick(1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", hif.in_ready, 1);
        chk("arst_busy", hif.busy, 0);
        chk("arst_ff_clk", ff_clk, 0);
        chk("arst_ff_j", ff_j, 0);
        chk("arst_ff_k", ff_k, 0);
        chk("arst_ff_clrn", ff_clrn, 0);
        chk("arst_phase_err", hif.phase_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        dp = dpulses;
        tick(50);
        chk("arst_no_pulses", dpulses - dp, 0);
        chk("arst_ff_q", ff_q, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
